// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle between the 5-stage pipeline and its central stall/flush controller.
//
// Request side (pipeline -> controller):
//   stallreq_if / stallreq_id / stallreq_ex / stallreq_mem : per-stage stall requests
//   exception_type_i : MEM-stage exception code (0 = none)
//   cp0_epc_i        : current EPC
//   if_busy_i        : instruction fetch outstanding on the instruction bus
// Control side (controller -> pipeline):
//   stall_o            : stall vector, bit k holds stage k (0=IF,1=ID,2=EX,3=MEM)
//   flush_o            : clears all pipeline registers
//   pc_load_o          : PC register loads new_pc_o this cycle
//   new_pc_o           : redirect target
//   redirect_pending_o : a redirect is waiting for the fetch to drain
//   stall_cycles_o     : consecutive stall cycle count
//   stall_timeout_o    : stall watchdog flag
//
// master = the controller, slave = the pipeline.
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic [31:0]      exception_type_i;
    logic [31:0]      cp0_epc_i;
    logic             if_busy_i;

    logic [3:0]       stall_o;
    logic             flush_o;
    logic             pc_load_o;
    logic [31:0]      new_pc_o;
    logic             redirect_pending_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic             stall_timeout_o;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  exception_type_i, cp0_epc_i, if_busy_i,
        output stall_o, flush_o, pc_load_o, new_pc_o, redirect_pending_o,
        output stall_cycles_o, stall_timeout_o
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output exception_type_i, cp0_epc_i, if_busy_i,
        input  stall_o, flush_o, pc_load_o, new_pc_o, redirect_pending_o,
        input  stall_cycles_o, stall_timeout_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for the 5-stage pipeline. Merges per-stage
// stall requests into a stall vector, turns MEM-stage exceptions / ERET into a
// flush plus PC redirect (deferring the PC load while a fetch is outstanding),
// and counts consecutive stall cycles for a watchdog flag.
//
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : pipeline_ctrl_if.master (requests in, stall/flush/redirect out)
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000E,
    parameter int          CNT_W      = 8,
    parameter int          TIMEOUT    = 200
) (
    input  logic            clk,
    input  logic            resetn,
    pipeline_ctrl_if.master bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_IF = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             exc;
    logic [31:0]      target;
    logic [3:0]       stall;
    logic             flush;
    logic             pc_load;
    logic             pending;
    logic [31:0]      new_pc;

    assign exc    = (bus.exception_type_i != 32'h0);
    assign target = (bus.exception_type_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;

    always_comb begin
        stall    = 4'b0000;
        flush    = 1'b0;
        pc_load  = 1'b0;
        pending  = 1'b0;
        new_pc   = new_pc_q;
        state_d  = state_q;
        new_pc_d = new_pc_q;

        // Control outputs stay low for as long as reset is held, independent
        // of the (already reset) state register.
        if (resetn) begin
            unique case (state_q)
                IDLE: begin
                    if (exc) begin
                        new_pc = target;
                    end
                    if (bus.stallreq_mem) begin
                        // MEM must complete before its exception can be taken.
                        stall = 4'b1111;
                    end else if (exc) begin
                        flush = 1'b1;
                        if (bus.if_busy_i) begin
                            // Fetch still in flight: hold IF and park the target.
                            stall    = 4'b0001;
                            new_pc_d = target;
                            state_d  = WAIT_IF;
                        end else begin
                            pc_load = 1'b1;
                        end
                    end else if (bus.stallreq_ex) begin
                        stall = 4'b0111;
                    end else if (bus.stallreq_id) begin
                        stall = 4'b0011;
                    end else if (bus.stallreq_if) begin
                        stall = 4'b0001;
                    end
                end
                WAIT_IF: begin
                    pending = 1'b1;
                    if (bus.if_busy_i) begin
                        stall = 4'b0001;
                    end else begin
                        pc_load = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Saturating consecutive-stall counter; any non-stall cycle clears it.
    always_comb begin
        cnt_d = '0;
        if (stall != 4'b0000) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
        timeout_d = (int'(cnt_d) >= TIMEOUT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            new_pc_q  <= 32'h0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_pc_q  <= new_pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.stall_o            = stall;
    assign bus.flush_o            = flush;
    assign bus.pc_load_o          = pc_load;
    assign bus.new_pc_o           = new_pc;
    assign bus.redirect_pending_o = pending;
    assign bus.stall_cycles_o     = cnt_q;
    assign bus.stall_timeout_o    = timeout_q;

endmodule
